// File: rtl/limn2600_sram_initiator_if.sv
// Request/response and SRAM bus bundle for the Limn2600 SRAM initiator.
// master = the initiator itself, slave = the core/SRAM side driving it.
interface limn2600_sram_initiator_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_cs;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_rdy;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_cs, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_rdy,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             mem_cs, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/limn2600_sram_initiator.sv
// Limn2600 SRAM bus initiator: queues word requests in a small FIFO and runs
// one cs/we/rdy transaction at a time, with a wait timeout and in-order
// single-cycle responses.
module limn2600_sram_initiator #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                          clk,
   input  logic                          rst,
   limn2600_sram_initiator_if.master     bus
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state, state_d;

   logic            fifo_we    [FIFO_DEPTH];
   logic [31:0]     fifo_addr  [FIFO_DEPTH];
   logic [31:0]     fifo_wdata [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [PW:0]     count;

   logic            mem_cs_q, mem_we_q;
   logic [31:0]     mem_addr_q, mem_wdata_q;
   logic [15:0]     cnt;
   logic [31:0]     rdata_q;
   logic            err_q;

   logic            full, empty, push, pop;
   logic            head_we, misaligned, timed_out;
   logic [31:0]     head_addr, head_wdata;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign push       = bus.req_valid && !full;
   // A stale rdy from the previous access must drain before a new cs is issued.
   assign pop        = (state == S_IDLE) && !empty && !bus.mem_rdy;
   assign head_we    = fifo_we[rd_ptr];
   assign head_addr  = fifo_addr[rd_ptr];
   assign head_wdata = fifo_wdata[rd_ptr];
   assign misaligned = (head_addr[1:0] != 2'b00);
   // rdy wins over timeout when both land in the same cycle.
   assign timed_out  = (state == S_WAIT) && !bus.mem_rdy && (cnt == TO_LAST);

   assign bus.req_ready = !full;
   assign bus.rsp_valid = (state == S_RESP);
   assign bus.rsp_rdata = (state == S_RESP) ? rdata_q : 32'h0;
   assign bus.rsp_err   = (state == S_RESP) && err_q;
   assign bus.mem_cs    = mem_cs_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (pop) state_d = misaligned ? S_RESP : S_WAIT;
         S_WAIT:  if (bus.mem_rdy || timed_out) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Queue storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_we[wr_ptr]    <= bus.req_we;
         fifo_addr[wr_ptr]  <= bus.req_addr;
         fifo_wdata[wr_ptr] <= bus.req_wdata;
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally at power-of-2 depth.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   // Bus drive, wait counter and response capture.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mem_cs_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
         cnt         <= 16'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (pop) begin
               if (misaligned) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'h0;
               end else begin
                  mem_cs_q    <= 1'b1;
                  mem_we_q    <= head_we;
                  mem_addr_q  <= head_addr;
                  mem_wdata_q <= head_wdata;
                  cnt         <= 16'h0;
               end
            end
            S_WAIT: begin
               if (bus.mem_rdy) begin
                  mem_cs_q <= 1'b0;
                  err_q    <= 1'b0;
                  rdata_q  <= mem_we_q ? 32'h0 : bus.mem_rdata;
               end else if (timed_out) begin
                  mem_cs_q <= 1'b0;
                  err_q    <= 1'b1;
                  rdata_q  <= 32'h0;
               end else if (cnt != 16'hFFFF) begin
                  cnt <= cnt + 16'h1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
